res_port_arbiter: RTL and testbench

//  Shares the single result-memory port (res_rd/res_wr/res_addr/res_do/res_di) between

---
 rtl/dt_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/res_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_res_port_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dt_pkg.sv
// Shared distance-transform constants and result-port tag types.
package dt_pkg;

  localparam int unsigned IMG_DIM    = 128;
  localparam int unsigned RES_ADDR_W = $clog2(IMG_DIM * IMG_DIM);
  localparam int unsigned RES_DATA_W = 8;
  localparam int unsigned MAX_REQ    = 4;
  localparam int unsigned REQ_IDX_W  = $clog2(MAX_REQ);

  typedef logic [REQ_IDX_W-1:0] req_idx_t;

  // Read tag carried alongside an in-flight memory read
  typedef struct packed {
    logic     vld;
    req_idx_t idx;
  } rd_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant with lock override; purely combinational.
module rr_arbiter
  import dt_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0] valid,
  input  req_idx_t        ptr,
  input  logic            lock_vld,
  input  req_idx_t        lock_own,
  output logic [NREQ-1:0] grant_c
);

  logic found;

  // Lock owner wins outright; otherwise first valid at/after ptr, then wrap to lowest
  always_comb begin
    grant_c = '0;
    found   = 1'b0;
    if (lock_vld) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (lock_own == REQ_IDX_W'(i)) grant_c[i] = 1'b1;
      end
    end else begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!found && valid[i] && (REQ_IDX_W'(i) >= ptr)) begin
          grant_c[i] = 1'b1;
          found      = 1'b1;
        end
      end
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!found && valid[i]) begin
          grant_c[i] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/res_port_arbiter.sv
// Shares the result-memory port between NREQ requesters; tagged fixed-latency reads.
module res_port_arbiter
  import dt_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned ADDR_W = RES_ADDR_W,
  parameter int unsigned DATA_W = RES_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ-1:0]          req_lock,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     res_rd,
  output logic                     res_wr,
  output logic [ADDR_W-1:0]        res_addr,
  output logic [DATA_W-1:0]        res_do,
  input  logic [DATA_W-1:0]        res_di
);

  req_idx_t          ptr_q, ptr_d;
  logic              lock_vld_q, lock_vld_d;
  req_idx_t          lock_own_q, lock_own_d;
  logic [NREQ-1:0]   grant_c;

  logic              acc_any;
  req_idx_t          acc_idx;
  logic              acc_we;
  logic              acc_lock;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              own_valid;
  logic              own_lock;

  rd_tag_t           tag1_q, tag2_q;
  logic [NREQ-1:0]   rsp_onehot;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .valid    (req_valid),
    .ptr      (ptr_q),
    .lock_vld (lock_vld_q),
    .lock_own (lock_own_q),
    .grant_c  (grant_c)
  );

  assign req_ready = grant_c;

  // Select the accepted request and look up the lock owner's request lines
  always_comb begin
    acc_any   = 1'b0;
    acc_idx   = '0;
    acc_we    = 1'b0;
    acc_lock  = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    own_valid = 1'b0;
    own_lock  = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (req_valid[i] && grant_c[i]) begin
        acc_any   = 1'b1;
        acc_idx   = REQ_IDX_W'(i);
        acc_we    = req_we[i];
        acc_lock  = req_lock[i];
        acc_addr  = req_addr[i*ADDR_W +: ADDR_W];
        acc_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
      if (lock_own_q == REQ_IDX_W'(i)) begin
        own_valid = req_valid[i];
        own_lock  = req_lock[i];
      end
    end
  end

  // Next pointer and lock: advance on accept, drop an idle lock once the owner lets go
  always_comb begin
    ptr_d      = ptr_q;
    lock_vld_d = lock_vld_q;
    lock_own_d = lock_own_q;
    if (acc_any) begin
      ptr_d      = (acc_idx == REQ_IDX_W'(NREQ - 1)) ? '0 : acc_idx + REQ_IDX_W'(1);
      lock_vld_d = acc_lock;
      lock_own_d = acc_idx;
    end else if (lock_vld_q && !own_valid && !own_lock) begin
      lock_vld_d = 1'b0;
    end
  end

  // Decode the oldest read tag into a one-hot response strobe
  always_comb begin
    rsp_onehot = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (tag2_q.vld && (tag2_q.idx == REQ_IDX_W'(i))) rsp_onehot[i] = 1'b1;
    end
  end

  // Arbitration state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      lock_vld_q <= 1'b0;
      lock_own_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_vld_q <= lock_vld_d;
      lock_own_q <= lock_own_d;
    end
  end

  // Memory port registers, two-stage read tag pipeline, response capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_rd    <= 1'b0;
      res_wr    <= 1'b0;
      res_addr  <= '0;
      res_do    <= '0;
      tag1_q    <= '0;
      tag2_q    <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      res_rd <= acc_any & ~acc_we;
      res_wr <= acc_any & acc_we;
      if (acc_any) begin
        res_addr <= acc_addr;
        res_do   <= acc_wdata;
      end
      tag1_q.vld <= acc_any & ~acc_we;
      tag1_q.idx <= acc_idx;
      tag2_q     <= tag1_q;
      rsp_valid  <= rsp_onehot;
      if (tag2_q.vld) rsp_data <= res_di;
    end
  end

endmodule

// File: tb/tb_res_port_arbiter.sv
// Bench for res_port_arbiter: reference model + memory environment + directed tests.
module tb_res_port_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 14;
  localparam int DW   = 8;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req_valid, req_we, req_lock;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ-1:0]      req_ready, rsp_valid;
  logic [DW-1:0]        rsp_data;
  logic                 res_rd, res_wr;
  logic [AW-1:0]        res_addr;
  logic [DW-1:0]        res_do;
  logic [DW-1:0]        res_di;

  int total = 0;
  int bad   = 0;

  res_port_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr), .res_do(res_do),
    .res_di(res_di)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory environment and the model's independent shadow copy
  logic [DW-1:0] env_mem [0:(1<<AW)-1];
  logic [DW-1:0] shadow  [0:(1<<AW)-1];

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'(a ^ (a >> 8));
  endfunction

  initial res_di = '0;
  always @(posedge clk) begin
    if (res_wr) env_mem[res_addr] <= res_do;
    if (res_rd) res_di <= env_mem[res_addr];
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state
  typedef struct { int due; int idx; logic [DW-1:0] data; } rsp_t;
  rsp_t          rq[$];
  int            m_ptr  = 0;
  int            m_lock = -1;
  int            cyc    = 0;
  logic          e_rd = 0, e_wr = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_do = '0;

  function automatic logic [NREQ-1:0] model_grant(input logic [NREQ-1:0] v, input int ptr, input int lk);
    logic [NREQ-1:0] g;
    g = '0;
    if (lk >= 0) begin
      g[lk] = 1'b1;
      return g;
    end
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (ptr + k) % NREQ;
      if (v[j]) begin
        g[j] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  // Per-cycle compare against the model, then advance the model over the next edge
  always @(negedge clk) begin
    logic [NREQ-1:0] e_ready, e_rsp;
    logic [DW-1:0]   e_data;
    int              acc;
    cyc++;
    if (reset) begin
      m_ptr = 0; m_lock = -1;
      e_rd = 0; e_wr = 0; e_addr = '0; e_do = '0;
      rq.delete();
    end
    e_ready = model_grant(req_valid, m_ptr, m_lock);
    cmp("req_ready", 32'(req_ready), 32'(e_ready));
    cmp("res_rd",    32'(res_rd),    32'(e_rd));
    cmp("res_wr",    32'(res_wr),    32'(e_wr));
    cmp("res_addr",  32'(res_addr),  32'(e_addr));
    if (e_wr) cmp("res_do", 32'(res_do), 32'(e_do));
    e_rsp  = '0;
    e_data = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e_rsp[rq[0].idx] = 1'b1;
      e_data = rq[0].data;
      void'(rq.pop_front());
    end
    cmp("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
    if (e_rsp != 0) cmp("rsp_data", 32'(rsp_data), 32'(e_data));
    if (!reset) begin
      e_rd = 0; e_wr = 0;
      acc = -1;
      for (int i = 0; i < NREQ; i++) if (req_valid[i] && e_ready[i]) acc = i;
      if (acc >= 0) begin
        e_rd   = !req_we[acc];
        e_wr   = req_we[acc];
        e_addr = req_addr[acc*AW +: AW];
        e_do   = req_wdata[acc*DW +: DW];
        if (req_we[acc]) shadow[e_addr] = e_do;
        else rq.push_back('{due: cyc + 3, idx: acc, data: shadow[e_addr]});
        m_ptr  = (acc + 1) % NREQ;
        m_lock = req_lock[acc] ? acc : -1;
      end else if (m_lock >= 0 && !req_valid[m_lock] && !req_lock[m_lock]) begin
        m_lock = -1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic w, input logic l, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_we[i]    = w;
    req_lock[i]  = l;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clr(input int i);
    req_valid[i] = 1'b0;
    req_lock[i]  = 1'b0;
  endtask

  task automatic apply_reset();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end by time %0t", $time);
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < (1 << AW); a++) begin
      env_mem[a] = init_val(a);
      shadow[a]  = init_val(a);
    end
    env_mem[14'h0081] = 8'h05;
    shadow[14'h0081]  = 8'h05;
    reset = 1'b1;
    req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    repeat (2) step();

    // 1: reset then idle
    reset = 1'b0;
    repeat (5) begin
      neg();
      cmp("t1_rd", 32'(res_rd), 32'd0);
    end
    cmp("t1_addr", 32'(res_addr), 32'd0);
    cmp("t1_rsp",  32'(rsp_valid), 32'd0);

    // 2: single read from requester 0
    step(); set_req(0, 1'b0, 1'b0, 14'h0081, 8'h00);
    neg();  cmp("t2_ready", 32'(req_ready), 32'h1);
    step(); clr(0);
    neg();  cmp("t2_rd", 32'(res_rd), 32'd1); cmp("t2_addr", 32'(res_addr), 32'h0081);
    neg();
    neg();  cmp("t2_rsp_v", 32'(rsp_valid), 32'h1); cmp("t2_rsp_d", 32'(rsp_data), 32'h05);

    // 3: both requesters continuously reading
    apply_reset();
    step(); set_req(0, 1'b0, 1'b0, 14'h0010, 8'h00); set_req(1, 1'b0, 1'b0, 14'h0020, 8'h00);
    neg();  cmp("t3_g0", 32'(req_ready), 32'h1);
    neg();  cmp("t3_g1", 32'(req_ready), 32'h2);
    neg();  cmp("t3_g2", 32'(req_ready), 32'h1);
    neg();  cmp("t3_r0_v", 32'(rsp_valid), 32'h1); cmp("t3_r0_d", 32'(rsp_data), 32'h10);
    neg();  cmp("t3_r1_v", 32'(rsp_valid), 32'h2); cmp("t3_r1_d", 32'(rsp_data), 32'h20);
    step(); clr(0); clr(1);
    repeat (4) neg();

    // 4: requester 1 locks the port for four writes while requester 0 waits
    step(); set_req(1, 1'b1, 1'b1, 14'h3F80, 8'hA0);
    neg();  cmp("t4_g0", 32'(req_ready), 32'h2);
    step(); set_req(1, 1'b1, 1'b1, 14'h3F81, 8'hA1); set_req(0, 1'b0, 1'b0, 14'h0200, 8'h00);
    neg();  cmp("t4_g1", 32'(req_ready), 32'h2);
    cmp("t4_wr", 32'(res_wr), 32'd1); cmp("t4_addr", 32'(res_addr), 32'h3F80);
    step(); set_req(1, 1'b1, 1'b1, 14'h3F82, 8'hA2);
    neg();  cmp("t4_g2", 32'(req_ready), 32'h2);
    step(); set_req(1, 1'b1, 1'b0, 14'h3F83, 8'hA3);
    neg();  cmp("t4_g3", 32'(req_ready), 32'h2);
    step(); clr(1);
    neg();  cmp("t4_g4", 32'(req_ready), 32'h1);
    step(); clr(0);
    repeat (4) neg();

    // 5: write then read back the same address
    step(); set_req(0, 1'b1, 1'b0, 14'h0100, 8'h07);
    neg();  cmp("t5_gw", 32'(req_ready), 32'h1);
    step(); set_req(0, 1'b0, 1'b0, 14'h0100, 8'h00);
    neg();  cmp("t5_wr", 32'(res_wr), 32'd1); cmp("t5_do", 32'(res_do), 32'h07);
    step(); clr(0);
    neg();  cmp("t5_rd", 32'(res_rd), 32'd1); cmp("t5_addr", 32'(res_addr), 32'h0100);
    neg();
    neg();  cmp("t5_rsp_v", 32'(rsp_valid), 32'h1); cmp("t5_rsp_d", 32'(rsp_data), 32'h07);
    repeat (2) neg();

    // 6: reset while a read is in flight
    step(); set_req(0, 1'b0, 1'b0, 14'h0040, 8'h00);
    step(); clr(0);
    neg();  cmp("t6_rd", 32'(res_rd), 32'd1);
    step(); reset = 1'b1;
    neg();  cmp("t6_rst_rd", 32'(res_rd), 32'd0); cmp("t6_rst_addr", 32'(res_addr), 32'd0);
    cmp("t6_rst_rsp", 32'(rsp_valid), 32'd0);
    step(); reset = 1'b0;
    set_req(0, 1'b0, 1'b0, 14'h0010, 8'h00); set_req(1, 1'b0, 1'b0, 14'h0020, 8'h00);
    neg();  cmp("t6_ptr0", 32'(req_ready), 32'h1); cmp("t6_rsp", 32'(rsp_valid), 32'd0);
    step(); clr(0); clr(1);
    repeat (5) neg();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
